// File: rtl/xsbl_rdma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xsbl_rdma                                                       |
// | Function : Read-DMA behind the X-Sobel stage. It fetches each completed    |
// |            frame line by line from DDR through the read arbiter, buffers   |
// |            the words in a FWFT FIFO and streams them out with valid/ready. |
// |            It double-buffers between BASE_A and BASE_B.                    |
// | Options  : XSBL_RDMA_STAT_EN adds the stall / backpressure counters in STAT|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module xsbl_rdma #(
   parameter int FIFO_AW = 9   // FIFO depth = 2**FIFO_AW words, must be >= 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ibus_cs,
   input  logic        ibus_wr,
   input  logic [5:0]  ibus_addr_7_2,
   input  logic [31:0] ibus_wrdata,
   output logic [31:0] ibus_rddata,
   input  logic [3:0]  xsbl_fcnt,
   output logic [3:0]  rdma_fcnt,
   output logic        drd_req,
   input  logic        drd_ack,
   input  logic        drd_vin,
   input  logic [31:0] drd_din,
   output logic        drd_vout,
   output logic [31:0] drd_dout,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready
);

   localparam logic [5:0] c_addr_ctrl   = 6'd0;
   localparam logic [5:0] c_addr_base_a = 6'd1;
   localparam logic [5:0] c_addr_base_b = 6'd2;
   localparam logic [5:0] c_addr_size   = 6'd3;
   localparam logic [5:0] c_addr_status = 6'd4;
   localparam logic [5:0] c_addr_stat   = 6'd5;

   localparam logic [FIFO_AW:0]   c_depth   = (FIFO_AW+1)'(2**FIFO_AW);
   localparam logic [FIFO_AW:0]   c_lvl_one = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] c_ptr_one = FIFO_AW'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_CMD0 = 3'd2,
      S_CMD1 = 3'd3,
      S_DATA = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // configuration registers
   logic        r_enable;
   logic [31:0] r_base_a;
   logic [31:0] r_base_b;
   logic [7:0]  r_size_w_m1;
   logic [9:0]  r_size_h_m1;

   // per-frame state, latched at frame start so register writes cannot disturb it
   state_t      r_state;
   logic [31:0] r_addr;
   logic [7:0]  r_w_m1;
   logic [9:0]  r_h_m1;
   logic [9:0]  r_line;
   logic [7:0]  r_wcnt;
   logic        r_req;
   logic        r_vout;
   logic [31:0] r_dout;
   logic [3:0]  r_fcnt;

   // FIFO
   logic [31:0]        r_mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_level;

   logic               w_push;
   logic               w_pop;
   logic [FIFO_AW:0]   w_free;
   logic               w_fits_cur;
   logic               w_fits_new;
   logic [8:0]         w_words;
   logic [31:0]        w_line_bytes;
   logic [31:0]        w_stat_rd;

   assign w_push       = (r_state == S_DATA) && drd_vin;
   assign w_pop        = (r_level != '0) && out_ready;
   assign w_free       = c_depth - r_level;
   // free >= W is the same as free > W-1, which avoids widening W to 9 bits
   assign w_fits_cur   = w_free > {{(FIFO_AW-7){1'b0}}, r_w_m1};
   assign w_fits_new   = w_free > {{(FIFO_AW-7){1'b0}}, r_size_w_m1};
   assign w_words      = {1'b0, r_w_m1} + 9'd1;
   assign w_line_bytes = {21'b0, w_words, 2'b00};

   assign drd_req   = r_req;
   assign drd_vout  = r_vout;
   assign drd_dout  = r_dout;
   assign rdma_fcnt = r_fcnt;
   assign out_valid = (r_level != '0);
   assign out_data  = (r_level != '0) ? r_mem[r_rd_ptr] : 32'd0;

   // register file writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable    <= 1'b0;
         r_base_a    <= 32'd0;
         r_base_b    <= 32'd0;
         r_size_w_m1 <= 8'd0;
         r_size_h_m1 <= 10'd0;
      end else if (ibus_cs && ibus_wr) begin
         case (ibus_addr_7_2)
            c_addr_ctrl:   r_enable <= ibus_wrdata[0];
            c_addr_base_a: r_base_a <= ibus_wrdata;
            c_addr_base_b: r_base_b <= ibus_wrdata;
            c_addr_size: begin
               r_size_w_m1 <= ibus_wrdata[7:0];
               r_size_h_m1 <= ibus_wrdata[25:16];
            end
            default: ;
         endcase
      end
   end

   // frame sequencer: request, two command beats, data beats, per line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= 32'd0;
         r_w_m1  <= 8'd0;
         r_h_m1  <= 10'd0;
         r_line  <= 10'd0;
         r_wcnt  <= 8'd0;
         r_req   <= 1'b0;
         r_vout  <= 1'b0;
         r_dout  <= 32'd0;
         r_fcnt  <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_enable && (xsbl_fcnt != r_fcnt)) begin
                  r_state <= S_REQ;
                  r_addr  <= r_fcnt[0] ? r_base_b : r_base_a;
                  r_w_m1  <= r_size_w_m1;
                  r_h_m1  <= r_size_h_m1;
                  r_line  <= 10'd0;
                  r_req   <= w_fits_new;
               end
            end
            S_REQ: begin
               if (r_req && drd_ack) begin
                  r_state <= S_CMD0;
                  r_vout  <= 1'b1;
                  r_dout  <= r_addr;
               end else if (w_fits_cur) begin
                  r_req <= 1'b1;
               end
            end
            S_CMD0: begin
               r_state <= S_CMD1;
               r_dout  <= {24'b0, r_w_m1};
            end
            S_CMD1: begin
               r_state <= S_DATA;
               r_vout  <= 1'b0;
               r_dout  <= 32'd0;
               r_wcnt  <= 8'd0;
            end
            S_DATA: begin
               if (drd_vin) begin
                  if (r_wcnt == r_w_m1) begin
                     r_req <= 1'b0;
                     if (r_line == r_h_m1) begin
                        r_state <= S_DONE;
                        r_fcnt  <= r_fcnt + 4'd1;
                     end else begin
                        r_state <= S_REQ;
                        r_line  <= r_line + 10'd1;
                        r_addr  <= r_addr + w_line_bytes;
                     end
                  end else begin
                     r_wcnt <= r_wcnt + 8'd1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage, not reset: emptiness is tracked by the level alone
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= drd_din;
      end
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + c_lvl_one;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - c_lvl_one;
         end
      end
   end

`ifdef XSBL_RDMA_STAT_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_bp_cnt;
   logic        w_stat_clr;

   assign w_stat_clr = ibus_cs && ibus_wr && (ibus_addr_7_2 == c_addr_stat);
   assign w_stat_rd  = {r_bp_cnt, r_stall_cnt};

   // saturating output-stall and request-backpressure counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= 16'd0;
         r_bp_cnt    <= 16'd0;
      end else if (w_stat_clr) begin
         r_stall_cnt <= 16'd0;
         r_bp_cnt    <= 16'd0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if ((r_state == S_REQ) && !r_req && (r_bp_cnt != 16'hFFFF)) begin
            r_bp_cnt <= r_bp_cnt + 16'd1;
         end
      end
   end
`else
   assign w_stat_rd = 32'd0;
`endif

   // register read mux
   always_comb begin
      ibus_rddata = 32'd0;
      case (ibus_addr_7_2)
         c_addr_ctrl:   ibus_rddata = {31'b0, r_enable};
         c_addr_base_a: ibus_rddata = r_base_a;
         c_addr_base_b: ibus_rddata = r_base_b;
         c_addr_size:   ibus_rddata = {6'b0, r_size_h_m1, 8'b0, r_size_w_m1};
         c_addr_status: begin
            ibus_rddata[0]               = (r_state != S_IDLE);
            ibus_rddata[7:4]             = r_fcnt;
            ibus_rddata[16+FIFO_AW:16]   = r_level;
         end
         c_addr_stat:   ibus_rddata = w_stat_rd;
         default:       ibus_rddata = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_xsbl_rdma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xsbl_rdma                                                    |
// | Function : Self-checking bench for xsbl_rdma: an arbiter/DDR model,        |
// |            a random-ready consumer and a frame-level reference model.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_xsbl_rdma;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ibus_cs = 1'b0;
   logic        ibus_wr = 1'b0;
   logic [5:0]  ibus_addr_7_2 = 6'd0;
   logic [31:0] ibus_wrdata = 32'd0;
   logic [31:0] ibus_rddata;
   logic [3:0]  xsbl_fcnt = 4'd0;
   logic [3:0]  rdma_fcnt;
   logic        drd_req;
   logic        drd_ack = 1'b0;
   logic        drd_vin = 1'b0;
   logic [31:0] drd_din = 32'd0;
   logic        drd_vout;
   logic [31:0] drd_dout;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   xsbl_rdma #(.FIFO_AW(9)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ibus_cs       (ibus_cs),
      .ibus_wr       (ibus_wr),
      .ibus_addr_7_2 (ibus_addr_7_2),
      .ibus_wrdata   (ibus_wrdata),
      .ibus_rddata   (ibus_rddata),
      .xsbl_fcnt     (xsbl_fcnt),
      .rdma_fcnt     (rdma_fcnt),
      .drd_req       (drd_req),
      .drd_ack       (drd_ack),
      .drd_vin       (drd_vin),
      .drd_din       (drd_din),
      .drd_vout      (drd_vout),
      .drd_dout      (drd_dout),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // reference model: one command per line, one expected word per data beat
   typedef struct {
      logic [31:0] addr;
      int          w;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] m_base_a = 32'd0;
   logic [31:0] m_base_b = 32'd0;
   int          m_w = 1;
   int          m_h = 1;
   logic [3:0]  m_fcnt = 4'd0;

   // arbiter / consumer model state
   int   a_ph = 0;
   int   a_dly = 0;
   int   a_cnt = 0;
   cmd_t a_cmd;
   int   rdy_mode = 1;   // 0 stall, 1 always ready, 2 random, 3 ready until budget
   int   pop_cnt = 0;
   int   pop_budget = 0;

   task automatic arb_step();
      drd_ack = 1'b0;
      drd_vin = 1'b0;
      drd_din = $urandom;
      case (a_ph)
         0: if (drd_req) begin
               if (cmd_q.size() == 0) begin
                  check("req_unexpected", 32'(drd_req), 32'd0);
               end else begin
                  a_cmd = cmd_q.pop_front();
                  a_dly = $urandom_range(0, 3);
                  a_ph  = 1;
               end
            end
         1: begin
               check("req_hold", 32'(drd_req), 32'd1);
               if (a_dly == 0) begin
                  drd_ack = 1'b1;
                  a_ph    = 2;
               end else begin
                  a_dly--;
               end
            end
         2: begin
               check("cmd0_vout", 32'(drd_vout), 32'd1);
               check("cmd0_addr", drd_dout, a_cmd.addr);
               drd_vin = 1'b1;     // junk beat, must be ignored
               a_ph    = 3;
            end
         3: begin
               check("cmd1_vout", 32'(drd_vout), 32'd1);
               check("cmd1_len", drd_dout, 32'(a_cmd.w - 1));
               drd_vin = 1'b1;     // junk beat, must be ignored
               a_cnt   = 0;
               a_ph    = 4;
            end
         4: if ($urandom_range(0, 3) != 0) begin
               drd_vin = 1'b1;
               exp_q.push_back(drd_din);
               a_cnt++;
               if (a_cnt == a_cmd.w) a_ph = 5;
            end
         default: begin
               check("req_drop", 32'(drd_req), 32'd0);
               drd_vin = 1'b1;     // junk beat outside DATA
               a_ph    = 0;
            end
      endcase
   endtask

   task automatic cons_step();
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         2:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = (pop_cnt < pop_budget);
      endcase
      if (out_valid && out_ready) begin
         pop_cnt++;
         if (exp_q.size() == 0) check("extra_word", out_data, 32'hDEADBEEF);
         else                   check("data", out_data, exp_q.pop_front());
      end
   endtask

   // DDR arbiter and downstream consumer, one step per cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            a_ph    = 0;
            drd_ack = 1'b0;
            drd_vin = 1'b0;
         end else begin
            arb_step();
            cons_step();
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
      ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr_7_2 = a; ibus_wrdata = d;
      tick();
      ibus_cs = 1'b0; ibus_wr = 1'b0;
   endtask

   task automatic reg_rd(input logic [5:0] a, output logic [31:0] d);
      ibus_addr_7_2 = a; ibus_cs = 1'b1; ibus_wr = 1'b0;
      #1;
      d = ibus_rddata;
      ibus_cs = 1'b0;
   endtask

   task automatic set_size(input int w, input int h);
      m_w = w;
      m_h = h;
      reg_wr(6'd3, {6'b0, 10'(h - 1), 8'b0, 8'(w - 1)});
   endtask

   // the frame about to be fetched uses the buffer chosen by frames done so far
   task automatic start_frame();
      logic [31:0] base;
      base = m_fcnt[0] ? m_base_b : m_base_a;
      for (int l = 0; l < m_h; l++) begin
         cmd_t c;
         c.addr = base + 32'(l * m_w * 4);
         c.w    = m_w;
         cmd_q.push_back(c);
      end
      xsbl_fcnt = xsbl_fcnt + 4'd1;
   endtask

   task automatic wait_frame(input int budget);
      int n;
      n = 0;
      m_fcnt = m_fcnt + 4'd1;
      while (((rdma_fcnt != m_fcnt) || (exp_q.size() != 0)) && (n < budget)) begin
         tick();
         n++;
      end
      check("fcnt", 32'(rdma_fcnt), 32'(m_fcnt));
      check("drained", 32'(exp_q.size()), 32'd0);
      check("cmds_used", 32'(cmd_q.size()), 32'd0);
   endtask

   task automatic run_frame(input int w, input int h, input int budget);
      set_size(w, h);
      start_frame();
      wait_frame(budget);
   endtask

   initial begin
      logic [31:0] rd;
      int          n;

      // reset state
      repeat (3) tick();
      check("rst_req", 32'(drd_req), 32'd0);
      check("rst_vout", 32'(drd_vout), 32'd0);
      check("rst_dout", drd_dout, 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_fcnt", 32'(rdma_fcnt), 32'd0);
      for (int a = 0; a < 6; a++) begin
         reg_rd(6'(a), rd);
         check("rst_reg", rd, 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // basic frame
      rdy_mode = 1;
      m_base_a = 32'h1000; reg_wr(6'd1, m_base_a);
      m_base_b = 32'h8000; reg_wr(6'd2, m_base_b);
      set_size(4, 2);
      reg_wr(6'd0, 32'd1);
      reg_rd(6'd0, rd);
      check("ctrl_rd", rd, 32'd1);
      reg_rd(6'd3, rd);
      check("size_rd", rd, 32'h0001_0003);
      start_frame();
      check("req_idle", 32'(drd_req), 32'd0);
      tick();
      check("req_first", 32'(drd_req), 32'd1);
      wait_frame(500);

      // buffer toggle with random sizes and random ready
      rdy_mode = 2;
      run_frame($urandom_range(1, 16), $urandom_range(1, 4), 2000);
      run_frame($urandom_range(1, 16), $urandom_range(1, 4), 2000);

      // backpressure: two full bursts fill the FIFO, the third waits for space
      rdy_mode = 0;
      set_size(256, 4);
      start_frame();
      n = 0;
      reg_rd(6'd4, rd);
      while ((rd[25:16] != 10'd512) && (n < 3000)) begin
         tick();
         reg_rd(6'd4, rd);
         n++;
      end
      check("bp_full", 32'(rd[25:16]), 32'd512);
      repeat (20) tick();
      reg_rd(6'd4, rd);
      check("bp_level", 32'(rd[25:16]), 32'd512);
      check("bp_busy", 32'(rd[0]), 32'd1);
      check("bp_req_low", 32'(drd_req), 32'd0);
      pop_cnt = 0;
      pop_budget = 256;
      rdy_mode = 3;
      n = 0;
      while (!drd_req && (n < 1000)) begin
         tick();
         n++;
      end
      check("bp_req_again", 32'(drd_req), 32'd1);
      check("bp_pops", 32'(pop_cnt), 32'd256);
      rdy_mode = 2;
      wait_frame(5000);

      // counter wrap, addresses wrapping modulo 2^32
      m_base_a = 32'hFFFF_FFF0; reg_wr(6'd1, m_base_a);
      m_base_b = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; reg_wr(6'd2, m_base_b);
      for (int f = 0; f < 16; f++) begin
         run_frame($urandom_range(1, 8), $urandom_range(1, 3), 2000);
      end

      // disable mid-frame: current frame finishes, no new one starts
      set_size(16, 3);
      start_frame();
      tick(); tick();
      reg_wr(6'd0, 32'd0);
      reg_rd(6'd4, rd);
      check("dis_busy", 32'(rd[0]), 32'd1);
      wait_frame(2000);
      xsbl_fcnt = xsbl_fcnt + 4'd1;
      repeat (50) tick();
      reg_rd(6'd4, rd);
      check("dis_idle", 32'(rd[0]), 32'd0);
      check("dis_req", 32'(drd_req), 32'd0);
      check("dis_fcnt", 32'(rdma_fcnt), 32'(m_fcnt));

      // reset in the middle of a data burst
      xsbl_fcnt = m_fcnt;
      rdy_mode = 0;
      set_size(4, 1);
      reg_wr(6'd0, 32'd1);
      start_frame();
      n = 0;
      while (!((a_ph == 4) && (a_cnt == 2)) && (n < 200)) begin
         tick();
         n++;
      end
      check("mid_burst", 32'(a_cnt), 32'd2);
      rst_n = 1'b0;
      #1;
      check("arst_req", 32'(drd_req), 32'd0);
      check("arst_vout", 32'(drd_vout), 32'd0);
      check("arst_dout", drd_dout, 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", out_data, 32'd0);
      check("arst_fcnt", 32'(rdma_fcnt), 32'd0);
      reg_rd(6'd4, rd);
      check("arst_status", rd, 32'd0);
      reg_rd(6'd0, rd);
      check("arst_ctrl", rd, 32'd0);
      cmd_q.delete();
      exp_q.delete();
      m_fcnt = 4'd0;
      xsbl_fcnt = 4'd0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // recovery after reset
      rdy_mode = 2;
      m_base_a = 32'h2000; reg_wr(6'd1, m_base_a);
      m_base_b = 32'h0;
      reg_wr(6'd0, 32'd1);
      run_frame(3, 2, 1000);

`ifdef XSBL_RDMA_STAT_EN
      // stall counter: ten stalled cycles after a clear
      rdy_mode = 0;
      set_size(2, 1);
      start_frame();
      m_fcnt = m_fcnt + 4'd1;
      n = 0;
      while ((rdma_fcnt != m_fcnt) && (n < 200)) begin
         tick();
         n++;
      end
      check("stat_fcnt", 32'(rdma_fcnt), 32'(m_fcnt));
      reg_wr(6'd5, 32'd0);
      repeat (10) tick();
      reg_rd(6'd5, rd);
      check("stat_stall", 32'(rd[15:0]), 32'd10);
      reg_wr(6'd5, 32'd0);
      reg_rd(6'd5, rd);
      check("stat_clear", 32'(rd[15:0]), 32'd0);
      rdy_mode = 2;
      n = 0;
      while ((exp_q.size() != 0) && (n < 200)) begin
         tick();
         n++;
      end
      check("stat_drain", 32'(exp_q.size()), 32'd0);
`else
      reg_wr(6'd5, 32'hFFFF_FFFF);
      reg_rd(6'd5, rd);
      check("stat_absent", rd, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xsbl_rdma.md
# xsbl_rdma

Read-DMA stage directly downstream of the X-Sobel stage. It waits until the X-Sobel stage has advanced its frame count, then fetches that frame from DDR line by line through the DDR Read Arbiter I/F. Fetched words go into an internal FIFO and leave as a valid/ready word stream for the next stage. The consumed-frame count it exports tells the X-Sobel stage when a frame buffer may be reused.

## Interface
- FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW words (512).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ibus_cs  in  1  register access strobe, one cycle.
- ibus_wr  in  1  1 = write, 0 = read.
- ibus_addr_7_2  in  6  word address of register.
- ibus_wrdata  in  32  write data.
- ibus_rddata  out  32  read data, combinational register mux; 0 for unmapped addresses.
- xsbl_fcnt  in  4  frames completed by the X-Sobel stage (wraps).
- rdma_fcnt  out  4  frames fully fetched by this block (wraps).
- drd_req  out  1  arbiter request.
- drd_ack  in  1  one-cycle grant pulse.
- drd_vin  in  1  read-data valid.
- drd_din  in  32  read data.
- drd_vout  out  1  command beat valid.
- drd_dout  out  32  command beat.
- out_valid  out  1  stream word valid.
- out_data  out  32  stream word.
- out_ready  in  1  downstream accepts word.

## Operation
- Registers (addr_7_2):
  - 0 CTRL: bit0 = enable.
  - 1 BASE_A, byte address.
  - 2 BASE_B, byte address.
  - 3 SIZE: [7:0] = words per line minus 1 (W = 1..256); [25:16] = lines minus 1 (H = 1..1024).
  - 4 STATUS (read-only): [0] busy, [7:4] rdma_fcnt, [16+FIFO_AW:16] FIFO level.
  - 5 STAT, see Configuration.
- Double buffering: frame buffer = BASE_B when rdma_fcnt[0]=1, else BASE_A. The base is latched at frame start.
- Line address: base + line*W*4, computed with a 32-bit running adder, modulo 2^32.
- State machine:
  - IDLE -> REQ when enable=1 and xsbl_fcnt != rdma_fcnt. At this transition, latch base, W and H, and set line to 0.
  - REQ: assert drd_req while FIFO free space ≥ W; hold drd_req once it is asserted. On drd_ack, go to CMD0.
  - CMD0: drd_vout=1, drd_dout = line address. Go to CMD1.
  - CMD1: drd_vout=1, drd_dout = {24'b0, W-1}. Go to DATA.
  - DATA: each drd_vin writes drd_din into the FIFO and increments the word count. On word W:
    - if line = H-1, go to DONE;
    - otherwise go to REQ with line+1.
  - DONE: rdma_fcnt increments, then go to IDLE.
- drd_req is 1 from REQ entry through the cycle of the last drd_vin of the burst. It drops the following cycle.
- drd_vin outside DATA is ignored.
- Clearing enable takes effect only in IDLE. A frame already in progress always completes.
- SIZE, BASE_A and BASE_B writes during a frame do not affect that frame.
- FIFO:
  - First-word-fall-through; out_valid = not empty.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - The free-space check covers the whole burst, so overflow cannot occur.

## Timing
- Reset values:
  - drd_req, drd_vout, out_valid = 0.
  - drd_dout, out_data, rdma_fcnt = 0.
  - all registers = 0; state = IDLE.
- Register write takes effect the cycle after ibus_cs.
- Earliest drd_req: 1 cycle after the xsbl_fcnt change is sampled.
- CMD0 is the cycle after drd_ack; CMD1 is 2 cycles after drd_ack.
- A word pushed in cycle n appears on out_data/out_valid in cycle n+1.
- rdma_fcnt updates 1 cycle after the last data beat of the final line.
- Wrap: 4-bit counters compare with inequality only, so 15 -> 0 behaves normally.
- Reset asserted mid-burst:
  - all state clears immediately and the FIFO empties;
  - the arbiter sees drd_req fall asynchronously.

## Configuration
- XSBL_RDMA_STAT_EN defined:
  - STAT register [15:0] counts cycles with out_valid=1 & out_ready=0, saturating at 0xFFFF.
  - STAT register [31:16] counts REQ cycles with drd_req=0 (FIFO backpressure), saturating.
  - Both counters clear on a write to STAT.
- XSBL_RDMA_STAT_EN undefined: no counters; STAT reads 0 and writes to it are ignored.

## Test plan
- Basic frame:
  - Stimulus: BASE_A=0x1000, W=4, H=2, enable; xsbl_fcnt 0->1; arbiter acks after 3 cycles; out_ready=1.
  - Response: commands (0x1000, 3) then (0x1010, 3); 8 words out in order; rdma_fcnt=1.
- Buffer toggle: second frame (xsbl_fcnt 1->2) uses BASE_B=0x8000 for its first command; third frame returns to BASE_A.
- Backpressure:
  - Stimulus: W=256, H=4, out_ready=0.
  - Response: two bursts fill the FIFO to 512; drd_req stays 0; after 256 pops the third request issues; no data is lost.
- Wrap and disable:
  - Stimulus: run 16 frames; then clear enable mid-frame.
  - Response: rdma_fcnt goes 15->0; the current frame completes; no new frame starts while xsbl_fcnt differs.
- Reset mid-DATA: assert rst_n=0 after 2 of 4 words. Required: all outputs at reset values, FIFO level 0, state IDLE.
- Stats (XSBL_RDMA_STAT_EN): hold out_ready=0 for 10 cycles with out_valid=1. Required: STAT[15:0]=10; a write to STAT clears it to 0.
